// File: rtl/load_ext_unit_pkg.sv
// Shared definitions for the MEM-stage load unit: load-op encodings and FSM states.
package load_ext_unit_pkg;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_D  = 3'b011,
    LD_BU = 3'b100,
    LD_HU = 3'b101,
    LD_WU = 3'b110
  } ld_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WAIT  = 2'b01,
    S_DRAIN = 2'b10,
    S_RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/load_ext_unit_lane_ext.sv
// Lane selection and sign/zero extension of a DRAM word, with alignment/op legality check.
module load_lane_ext
  import load_ext_unit_pkg::*;
#(
  parameter int  DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OFF_W-1:0]  offset,
  input  ld_op_e            op,
  output logic [DATA_W-1:0] data,
  output logic              illegal
);

  logic [DATA_W-1:0] lane;

  // Aligned accesses only reach the data path, so shifting by the byte offset
  // lands every lane at bit 0.
  assign lane = rdata >> {offset, 3'b000};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    data    = '0;
    illegal = 1'b0;
    case (op)
      LD_B:  data = DATA_W'($signed(lane[7:0]));
      LD_BU: data = DATA_W'(lane[7:0]);
      LD_H: begin
        illegal = offset[0];
        data    = DATA_W'($signed(lane[15:0]));
      end
      LD_HU: begin
        illegal = offset[0];
        data    = DATA_W'(lane[15:0]);
      end
      LD_W: begin
        illegal = |offset[1:0];
        data    = DATA_W'($signed(lane[31:0]));
      end
      LD_WU: begin
        illegal = (DATA_W != 64) || (|offset[1:0]);
        data    = DATA_W'(lane[31:0]);
      end
      LD_D: begin
        illegal = (DATA_W != 64) || (|offset);
        data    = lane;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_ext_unit.sv
// MEM-stage load unit: issues an aligned DRAM read, waits for the response,
// extends the selected lane and hands it to WB with a valid/ready handshake.
module load_ext_unit
  import load_ext_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              cpu_clk,
  input  logic              cpu_rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_op,
  input  logic [RD_W-1:0]   req_rd,
  input  logic              flush,
  output logic              dram_req,
  output logic [ADDR_W-1:0] dram_addr,
  input  logic              dram_rvalid,
  input  logic [DATA_W-1:0] dram_rdata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [RD_W-1:0]   res_rd,
  output logic              res_exc,
  output logic              busy
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  off_q, lane_off;
  ld_op_e            op_q, lane_op;
  logic [DATA_W-1:0] lane_data;
  logic              lane_illegal;
  logic              accept;

  assign req_ready = (state_q == S_IDLE) && !flush;
  assign accept    = req_valid && req_ready;

  // One extender serves both jobs: legality of the incoming request while idle,
  // and extension of the returning data using the latched offset/op otherwise.
  assign lane_off = (state_q == S_IDLE) ? req_addr[OFF_W-1:0] : off_q;
  assign lane_op  = (state_q == S_IDLE) ? ld_op_e'(req_op) : op_q;

  load_lane_ext #(.DATA_W(DATA_W)) u_lane (
    .rdata   (dram_rdata),
    .offset  (lane_off),
    .op      (lane_op),
    .data    (lane_data),
    .illegal (lane_illegal)
  );

  assign dram_req  = accept && !lane_illegal;
  assign dram_addr = dram_req ? {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign res_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = lane_illegal ? S_RESP : S_WAIT;
      S_WAIT: begin
        // A flush coinciding with the response has nothing left to absorb.
        if (flush)            state_d = dram_rvalid ? S_IDLE : S_DRAIN;
        else if (dram_rvalid) state_d = S_RESP;
      end
      S_DRAIN: if (dram_rvalid) state_d = S_IDLE;
      S_RESP:  if (res_ready || flush) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!cpu_rstn) begin
      state_q  <= S_IDLE;
      off_q    <= '0;
      op_q     <= LD_B;
      res_data <= '0;
      res_rd   <= '0;
      res_exc  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        off_q    <= req_addr[OFF_W-1:0];
        op_q     <= ld_op_e'(req_op);
        res_rd   <= req_rd;
        res_exc  <= lane_illegal;
        res_data <= '0;
      end else if (state_q == S_WAIT && dram_rvalid && !flush) begin
        res_data <= lane_data;
      end
    end
  end

endmodule

// File: tb/tb_load_ext_unit.sv
// Directed self-checking bench for load_ext_unit (32-bit and 64-bit DRAM instances).
module tb_load_ext_unit;
  import load_ext_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // 32-bit instance
  logic        cpu_rstn, req_valid, flush, dram_rvalid, res_ready;
  logic [31:0] req_addr, dram_rdata;
  logic [2:0]  req_op;
  logic [4:0]  req_rd;
  logic        req_ready, dram_req, res_valid, res_exc, busy;
  logic [31:0] dram_addr, res_data;
  logic [4:0]  res_rd;

  // 64-bit instance
  logic        req_valid_w, flush_w, dram_rvalid_w, res_ready_w;
  logic [31:0] req_addr_w;
  logic [63:0] dram_rdata_w;
  logic [2:0]  req_op_w;
  logic [4:0]  req_rd_w;
  logic        req_ready_w, dram_req_w, res_valid_w, res_exc_w, busy_w;
  logic [31:0] dram_addr_w;
  logic [63:0] res_data_w;
  logic [4:0]  res_rd_w;

  load_ext_unit #(.DATA_W(32), .ADDR_W(32), .RD_W(5)) u_dut (
    .cpu_clk(clk), .cpu_rstn(cpu_rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_op(req_op), .req_rd(req_rd), .flush(flush),
    .dram_req(dram_req), .dram_addr(dram_addr),
    .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_exc(res_exc), .busy(busy)
  );

  load_ext_unit #(.DATA_W(64), .ADDR_W(32), .RD_W(5)) u_dut_w (
    .cpu_clk(clk), .cpu_rstn(cpu_rstn),
    .req_valid(req_valid_w), .req_ready(req_ready_w), .req_addr(req_addr_w),
    .req_op(req_op_w), .req_rd(req_rd_w), .flush(flush_w),
    .dram_req(dram_req_w), .dram_addr(dram_addr_w),
    .dram_rvalid(dram_rvalid_w), .dram_rdata(dram_rdata_w),
    .res_valid(res_valid_w), .res_ready(res_ready_w), .res_data(res_data_w),
    .res_rd(res_rd_w), .res_exc(res_exc_w), .busy(busy_w)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Presents a request for one cycle; returns at the negedge after the accept edge.
  task automatic send(input string tag, input logic [31:0] addr, input logic [2:0] op,
                      input logic [4:0] rd, input logic exp_dreq, input logic [31:0] exp_daddr);
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_op = op; req_rd = rd;
    #1;
    check({tag, ".req_ready"}, req_ready, 1'b1);
    check({tag, ".dram_req"}, dram_req, exp_dreq);
    check({tag, ".dram_addr"}, dram_addr, exp_daddr);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ".dram_req_after"}, dram_req, 1'b0);
  endtask

  // Delivers read data so that dram_rvalid is sampled lat cycles after the accept edge.
  task automatic respond(input string tag, input logic [31:0] rdata, input int lat);
    for (int i = 0; i < lat; i++) begin
      check({tag, ".wait_valid"}, res_valid, 1'b0);
      check({tag, ".wait_busy"}, busy, 1'b1);
      if (i == lat - 1) begin
        dram_rvalid = 1'b1; dram_rdata = rdata;
      end
      @(negedge clk);
    end
    dram_rvalid = 1'b0; dram_rdata = '0;
  endtask

  // Checks the pending result, then accepts it and confirms the unit returns to idle.
  task automatic take(input string tag, input logic [31:0] exp_data, input logic [4:0] exp_rd,
                      input logic exp_exc);
    check({tag, ".res_valid"}, res_valid, 1'b1);
    check({tag, ".res_data"}, res_data, exp_data);
    check({tag, ".res_rd"}, res_rd, exp_rd);
    check({tag, ".res_exc"}, res_exc, exp_exc);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, ".valid_drop"}, res_valid, 1'b0);
    check({tag, ".idle"}, busy, 1'b0);
  endtask

  task automatic run_w(input string tag, input logic [31:0] addr, input logic [2:0] op,
                       input logic [63:0] rdata, input logic exp_dreq, input logic [31:0] exp_daddr,
                       input logic [63:0] exp_data, input logic exp_exc);
    @(negedge clk);
    req_valid_w = 1'b1; req_addr_w = addr; req_op_w = op; req_rd_w = 5'd3;
    #1;
    check({tag, ".dram_req"}, dram_req_w, exp_dreq);
    check({tag, ".dram_addr"}, dram_addr_w, exp_daddr);
    @(negedge clk);
    req_valid_w = 1'b0;
    if (exp_dreq) begin
      check({tag, ".wait_valid"}, res_valid_w, 1'b0);
      dram_rvalid_w = 1'b1; dram_rdata_w = rdata;
      @(negedge clk);
      dram_rvalid_w = 1'b0; dram_rdata_w = '0;
    end
    check({tag, ".res_valid"}, res_valid_w, 1'b1);
    check({tag, ".res_data"}, res_data_w, exp_data);
    check({tag, ".res_exc"}, res_exc_w, exp_exc);
    res_ready_w = 1'b1;
    @(negedge clk);
    res_ready_w = 1'b0;
    check({tag, ".idle"}, busy_w, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cpu_rstn = 1'b0; req_valid = 1'b0; flush = 1'b0; dram_rvalid = 1'b0; res_ready = 1'b0;
    req_addr = '0; dram_rdata = '0; req_op = '0; req_rd = '0;
    req_valid_w = 1'b0; flush_w = 1'b0; dram_rvalid_w = 1'b0; res_ready_w = 1'b0;
    req_addr_w = '0; dram_rdata_w = '0; req_op_w = '0; req_rd_w = '0;
    repeat (2) @(negedge clk);
    cpu_rstn = 1'b1;
    check("rst.res_valid", res_valid, 1'b0);
    check("rst.res_data", res_data, 32'h0);
    check("rst.busy", busy, 1'b0);
    check("rst.ready", req_ready, 1'b1);
    check("rst.busy_w", busy_w, 1'b0);

    // LD_B, offset 3, latency 1: sign-extended 0x80.
    send("ldb", 32'h0000_1003, LD_B, 5'd5, 1'b1, 32'h0000_1000);
    respond("ldb", 32'h80FF_7F01, 1);
    take("ldb", 32'hFFFF_FF80, 5'd5, 1'b0);

    // LD_HU, latency 3, WB stalls for 4 cycles: result must hold still.
    send("ldhu", 32'h0000_2002, LD_HU, 5'd6, 1'b1, 32'h0000_2000);
    respond("ldhu", 32'hBEEF_1234, 3);
    for (int i = 0; i < 4; i++) begin
      check("ldhu.hold_valid", res_valid, 1'b1);
      check("ldhu.hold_data", res_data, 32'h0000_BEEF);
      check("ldhu.hold_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    take("ldhu", 32'h0000_BEEF, 5'd6, 1'b0);

    // Signed half and full word.
    send("ldh", 32'h0000_5002, LD_H, 5'd11, 1'b1, 32'h0000_5000);
    respond("ldh", 32'h8001_0000, 2);
    take("ldh", 32'hFFFF_8001, 5'd11, 1'b0);
    send("ldw", 32'h0000_6000, LD_W, 5'd12, 1'b1, 32'h0000_6000);
    respond("ldw", 32'hDEAD_BEEF, 1);
    take("ldw", 32'hDEAD_BEEF, 5'd12, 1'b0);

    // Exceptions: no DRAM strobe, result the cycle after accept.
    send("misw", 32'h0000_3001, LD_W, 5'd4, 1'b0, 32'h0);
    take("misw", 32'h0, 5'd4, 1'b1);
    send("wu32", 32'h0000_3000, LD_WU, 5'd4, 1'b0, 32'h0);
    take("wu32", 32'h0, 5'd4, 1'b1);
    send("d32", 32'h0000_3000, LD_D, 5'd4, 1'b0, 32'h0);
    take("d32", 32'h0, 5'd4, 1'b1);
    send("badop", 32'h0000_3000, 3'b111, 5'd4, 1'b0, 32'h0);
    take("badop", 32'h0, 5'd4, 1'b1);

    // Flush in WAIT, response absorbed in DRAIN, then a fresh load.
    send("fl", 32'h0000_4000, LD_H, 5'd7, 1'b1, 32'h0000_4000);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl.drain_busy", busy, 1'b1);
    check("fl.drain_ready", req_ready, 1'b0);
    @(negedge clk);
    check("fl.drain_busy2", busy, 1'b1);
    dram_rvalid = 1'b1; dram_rdata = 32'h1111_2222;
    @(negedge clk);
    dram_rvalid = 1'b0;
    check("fl.no_valid", res_valid, 1'b0);
    check("fl.idle", busy, 1'b0);
    send("fl2", 32'h0000_4001, LD_B, 5'd8, 1'b1, 32'h0000_4000);
    respond("fl2", 32'h0000_7F00, 1);
    take("fl2", 32'h0000_007F, 5'd8, 1'b0);

    // Flush and response together in WAIT.
    send("flrv", 32'h0000_4100, LD_W, 5'd9, 1'b1, 32'h0000_4100);
    flush = 1'b1; dram_rvalid = 1'b1; dram_rdata = 32'h5555_5555;
    @(negedge clk);
    flush = 1'b0; dram_rvalid = 1'b0;
    check("flrv.no_valid", res_valid, 1'b0);
    check("flrv.idle", busy, 1'b0);

    // Flush in RESP drops the result.
    send("flresp", 32'h0000_4201, LD_H, 5'd9, 1'b0, 32'h0);
    check("flresp.valid", res_valid, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flresp.dropped", res_valid, 1'b0);
    check("flresp.idle", busy, 1'b0);

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_4300; req_op = LD_W; flush = 1'b1;
    #1;
    check("flidle.ready", req_ready, 1'b0);
    check("flidle.dram_req", dram_req, 1'b0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flidle.idle", busy, 1'b0);

    // Reset mid-WAIT, then a stray late response.
    send("rstw", 32'h0000_7000, LD_W, 5'd9, 1'b1, 32'h0000_7000);
    cpu_rstn = 1'b0;
    @(negedge clk);
    cpu_rstn = 1'b1;
    dram_rvalid = 1'b1; dram_rdata = 32'hCAFE_F00D;
    #1;
    check("rstw.res_valid", res_valid, 1'b0);
    check("rstw.res_data", res_data, 32'h0);
    check("rstw.res_rd", res_rd, 5'd0);
    check("rstw.res_exc", res_exc, 1'b0);
    check("rstw.busy", busy, 1'b0);
    check("rstw.dram_addr", dram_addr, 32'h0);
    @(negedge clk);
    dram_rvalid = 1'b0;
    check("rstw.late_ignored", res_valid, 1'b0);
    check("rstw.late_idle", busy, 1'b0);
    send("post", 32'h0000_7002, LD_BU, 5'd10, 1'b1, 32'h0000_7000);
    respond("post", 32'h00AB_0000, 2);
    take("post", 32'h0000_00AB, 5'd10, 1'b0);

    // 64-bit DRAM: doubleword passthrough, upper-word LD_WU, misaligned LD_D.
    run_w("w.ldd", 32'h0000_0008, LD_D, 64'h8000_0000_0000_0001, 1'b1, 32'h0000_0008,
          64'h8000_0000_0000_0001, 1'b0);
    run_w("w.ldwu", 32'h0000_000C, LD_WU, 64'hFFFF_FFFF_0000_0000, 1'b1, 32'h0000_0008,
          64'h0000_0000_FFFF_FFFF, 1'b0);
    run_w("w.misd", 32'h0000_0004, LD_D, 64'h0, 1'b0, 32'h0, 64'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/load_ext_unit.md
Name: load_ext_unit

Overview:
- MEM-stage load unit for the pipelined miniLA core.
- Accepts one load request, issues a word-aligned DRAM read, and waits for a variable-latency read response.
- Selects the byte/half/word/double lane by address offset, then sign- or zero-extends it.
- Returns the result to WB with a valid/ready handshake and flags misaligned accesses without touching DRAM.

Parameters:
- DATA_W, 32, DRAM data width; legal values 32 or 64.
- ADDR_W, 32, byte address width.
- RD_W, 5, destination register index width.

Ports:
- cpu_clk  in  1  core clock; all state updates on rising edge.
- cpu_rstn  in  1  synchronous active-low reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_op  in  3  load type: LD_B, LD_H, LD_W, LD_BU, LD_HU, LD_WU, LD_D.
- req_rd  in  RD_W  destination register, carried to result.
- flush  in  1  pipeline flush; kills in-flight load.
- dram_req  out  1  one-cycle read strobe.
- dram_addr  out  ADDR_W  read address, aligned to DATA_W/8 bytes.
- dram_rvalid  in  1  read data valid.
- dram_rdata  in  DATA_W  read data.
- res_valid  out  1  result available.
- res_ready  in  1  WB accepts result.
- res_data  out  DATA_W  extended load data.
- res_rd  out  RD_W  destination register.
- res_exc  out  1  misalign or illegal-op exception; res_data is 0 when set.
- busy  out  1  high in any state other than IDLE; drives pipeline stall.

Behaviour:
- Reset (cpu_rstn=0 at a clock edge):
  - State goes to IDLE.
  - res_valid, res_data, res_rd, res_exc, dram_req, dram_addr and busy all go to 0.
  - Reset overrides any state, including mid-WAIT. A dram_rvalid arriving after reset is ignored.
- States and transitions:
  - IDLE → WAIT: request accepted and legal.
  - IDLE → RESP: request accepted but misaligned or illegal.
  - WAIT → RESP: on dram_rvalid.
  - WAIT → DRAIN: on flush.
  - DRAIN → IDLE: on dram_rvalid.
  - RESP → IDLE: on res_ready or flush.
- Request acceptance:
  - req_ready = (state==IDLE) && !flush.
  - A request is accepted when req_valid && req_ready. Offset, op and rd are latched.
- Legality:
  - LD_H/LD_HU require offset[0]==0.
  - LD_W/LD_WU require offset[1:0]==0.
  - LD_D requires offset[2:0]==0 and DATA_W==64.
  - LD_WU and LD_D are illegal when DATA_W==32.
  - Undefined req_op codes are illegal.
- DRAM strobe:
  - dram_req is combinational, high only in the accept cycle of a legal request. It is never high for illegal requests.
  - dram_addr = req_addr with its low log2(DATA_W/8) bits cleared.
- WAIT: hold until dram_rvalid. Result is registered in that cycle; res_valid goes high the next cycle.
- Latency: accept at cycle T, rvalid at T+L with L≥1, res_valid at T+L+1. Exception result: res_valid at T+1.
- Lane selection:
  - Byte lane = offset; half lane = offset[..1]; word lane = offset[..2].
  - Signed ops replicate the lane MSB into the upper bits; U ops fill the upper bits with zero.
- RESP:
  - res_valid stays high and res_data/res_rd/res_exc stay stable until res_ready.
  - On res_ready, res_valid drops next cycle. No new request is accepted until back in IDLE.
- Flush:
  - In WAIT: go to DRAIN, absorb exactly one dram_rvalid, discard it, go to IDLE. No res_valid is produced.
  - In RESP: drop the result; res_valid=0 next cycle.
  - In IDLE: blocks acceptance for that cycle.
  - flush and dram_rvalid in the same WAIT cycle: data is discarded, go to IDLE.
- dram_rvalid outside WAIT/DRAIN is ignored.

Decomposition:
- Shared package (defines.vh additions): LD_* op encodings, state encodings S_IDLE/S_WAIT/S_DRAIN/S_RESP.
- The existing EXT2_SEL_* constants are superseded by LD_*.
- One combinational sub-module, load_lane_ext: (rdata, offset, op) → extended data plus illegal flag, parametrised by DATA_W.
- FSM and registers stay in the top module.

Test Plan:
- LD_B, addr 0x1003, rdata 0x80FF_7F01, L=1 → res_valid at T+2, res_data 0xFFFF_FF80, res_exc 0, dram_addr 0x1000.
- LD_HU, addr 0x2002, rdata 0xBEEF_1234, L=3 with res_ready held low 4 cycles → res_data 0x0000_BEEF stable throughout, one transfer only.
- LD_W, addr 0x3001 → dram_req never asserted, res_valid at T+1, res_exc 1, res_data 0.
- LD_H, addr 0x4000, flush at T+1, rvalid at T+3, then a new LD_B to 0x4001 → first result never appears; second load completes correctly with busy high throughout DRAIN.
- DATA_W=64: LD_D addr 0x8 rdata 0x8000_0000_0000_0001 → exact passthrough. LD_WU addr 0xC rdata 0xFFFF_FFFF_0000_0000 → 0x0000_0000_FFFF_FFFF.
- cpu_rstn low for 1 cycle mid-WAIT, then a late dram_rvalid → all outputs 0, no res_valid, next request served normally.
